// File: rtl/pattern_player_pkg.sv
// Shared types and constants for the pattern_player memory-game display.
// Box geometry and colours are indexed by the 2-bit box number from the sequence word.
package pattern_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GAP   = 3'd1,
        DRAW  = 3'd2,
        HOLD  = 3'd3,
        ERASE = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Packed arrays: element [0] is box0 (last item in each concatenation).
    localparam logic [3:0][7:0] BOX_X      = {8'd92, 8'd44, 8'd92, 8'd44};
    localparam logic [3:0][6:0] BOX_Y      = {7'd72, 7'd72, 7'd24, 7'd24};
    localparam logic [3:0][2:0] BOX_COLOUR = {3'd6, 3'd1, 3'd2, 3'd4};
    localparam logic [2:0]      BG_COLOUR  = 3'd7;

    // Visible hold time after the level speed-up, saturating at the floor.
    function automatic logic [31:0] hold_ticks(input logic [31:0] base,
                                               input logic [31:0] cut,
                                               input logic [31:0] floor_v);
        if (cut >= base || (base - cut) < floor_v) begin
            return floor_v;
        end
        return base - cut;
    endfunction

endpackage

// File: rtl/pattern_player_box_scanner.sv
// Row-major pixel scan of one BOX_SIZE x BOX_SIZE box with registered VGA outputs.
// Counters advance only while go is high, so a frozen go resumes on the same pixel.
module box_scanner #(
    parameter int BOX_SIZE = 24
) (
    input  logic       iClock,
    input  logic       iResetn,
    input  logic       go,
    input  logic [7:0] base_x,
    input  logic [6:0] base_y,
    input  logic [2:0] colour,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       last
);

    localparam int            CW   = (BOX_SIZE > 1) ? $clog2(BOX_SIZE) : 1;
    localparam logic [CW-1:0] EDGE = CW'(BOX_SIZE - 1);

    logic [CW-1:0] col;
    logic [CW-1:0] row;

    // High on the edge that registers the final pixel of the box.
    assign last = go && (col == EDGE) && (row == EDGE);

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            col     <= '0;
            row     <= '0;
            oX      <= '0;
            oY      <= '0;
            oColour <= '0;
            oPlot   <= 1'b0;
        end else begin
            oPlot <= go;
            if (go) begin
                oX      <= base_x + 8'(col);
                oY      <= base_y + 7'(row);
                oColour <= colour;
                if (col == EDGE) begin
                    col <= '0;
                    row <= (row == EDGE) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pattern_player.sv
// Plays a latched memory-game sequence as lit boxes on a 2x2 grid via the VGA adapter.
// Optional PATTERN_PAUSE_EN adds a pause input that freezes timers and the pixel scan.
module pattern_player
    import pattern_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int BOX_SIZE  = 24,
    parameter int ON_TICKS  = 50000000,
    parameter int ON_STEP   = 2500000,
    parameter int MIN_ON    = 10000000,
    parameter int OFF_TICKS = 25000000
) (
    input  logic                 iClock,
    input  logic                 iResetn,
    input  logic                 start,
    input  logic [3:0]           level,
`ifdef PATTERN_PAUSE_EN
    input  logic                 pause,
`endif
    input  logic [2*MAX_LEN-1:0] seq_data,
    output logic [7:0]           oX,
    output logic [6:0]           oY,
    output logic [2:0]           oColour,
    output logic                 oPlot,
    output logic                 busy,
    output logic                 done
);

    localparam int            TMAX     = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int            TW       = $clog2(TMAX + 1);
    localparam int            LW       = $clog2(MAX_LEN + 1);
    localparam int            IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

    // Handshake: start is sampled only in IDLE; busy is high from the accept edge
    // through the one-cycle done pulse in DONE, and falls on the following cycle.
    state_t state;
    state_t state_n;

    logic [TW-1:0]          timer;
    logic [TW-1:0]          hold_last;
    logic [IW-1:0]          idx;
    logic [IW-1:0]          len_last;
    logic [2*MAX_LEN-1:0]   seq_q;

    logic [LW-1:0]          len_eff;
    logic [31:0]            hold_cut;
    logic [31:0]            hold_now;
    logic [1:0]             cur_box;
    logic [2:0]             scan_colour;
    logic                   scan_go;
    logic                   scan_last;
    logic                   run;

`ifdef PATTERN_PAUSE_EN
    assign run = ~pause;
`else
    assign run = 1'b1;
`endif

    always_comb begin
        len_eff = LW'(level);
        if (level == 4'd0) begin
            len_eff = LW'(1);
        end else if (int'(level) > MAX_LEN) begin
            len_eff = LW'(MAX_LEN);
        end
    end

    assign hold_cut = 32'(len_eff - 1'b1) * 32'(ON_STEP);
    assign hold_now = hold_ticks(32'(ON_TICKS), hold_cut, 32'(MIN_ON));

    assign cur_box     = seq_q[{idx, 1'b0} +: 2];
    assign scan_go     = ((state == DRAW) || (state == ERASE)) && run;
    assign scan_colour = (state == ERASE) ? BG_COLOUR : BOX_COLOUR[cur_box];

    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = GAP;
            GAP:     if (run && timer == OFF_LAST) state_n = DRAW;
            DRAW:    if (scan_last) state_n = HOLD;
            HOLD:    if (run && timer == hold_last) state_n = ERASE;
            ERASE:   if (scan_last) state_n = (idx == len_last) ? DONE : GAP;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Timer restarts on every state change, so GAP/HOLD always count from zero.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            timer     <= '0;
            hold_last <= '0;
            idx       <= '0;
            len_last  <= '0;
            seq_q     <= '0;
        end else begin
            if (state_n != state) begin
                timer <= '0;
            end else if (((state == GAP) || (state == HOLD)) && run) begin
                timer <= timer + 1'b1;
            end

            if ((state == IDLE) && start) begin
                idx       <= '0;
                len_last  <= IW'(len_eff - 1'b1);
                hold_last <= TW'(hold_now - 32'd1);
                seq_q     <= seq_data;
            end else if ((state == ERASE) && scan_last && (idx != len_last)) begin
                idx <= idx + 1'b1;
            end
        end
    end

    box_scanner #(
        .BOX_SIZE(BOX_SIZE)
    ) u_scanner (
        .iClock (iClock),
        .iResetn(iResetn),
        .go     (scan_go),
        .base_x (BOX_X[cur_box]),
        .base_y (BOX_Y[cur_box]),
        .colour (scan_colour),
        .oX     (oX),
        .oY     (oY),
        .oColour(oColour),
        .oPlot  (oPlot),
        .last   (scan_last)
    );

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_pattern_player.sv
// Directed bench for pattern_player with a pixel scoreboard and per-cycle busy/done checks.
// A second instance with MAX_LEN=4 covers the level clamp above MAX_LEN.
module tb_pattern_player;

    logic        clk = 1'b0;
    logic        iResetn;
    logic        start;
    logic [3:0]  level;
    logic [31:0] seq_data;
    logic [7:0]  oX;
    logic [6:0]  oY;
    logic [2:0]  oColour;
    logic        oPlot;
    logic        busy;
    logic        done;

    logic        start2;
    logic [3:0]  level2;
    logic [7:0]  seq2;
    logic [7:0]  oX2;
    logic [6:0]  oY2;
    logic [2:0]  oColour2;
    logic        oPlot2;
    logic        busy2;
    logic        done2;

`ifdef PATTERN_PAUSE_EN
    logic        pause;
`endif

    logic [17:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          k = 0;
    int          exp_done_k = 0;
    int          p2 = 0;
    int          done2_k = 0;
    int          p_lo = 0;
    int          p_hi = 0;

    int bx[4] = '{44, 92, 44, 92};
    int by[4] = '{24, 24, 72, 72};
    int bc[4] = '{4, 2, 1, 6};

    always #5 clk = ~clk;

    pattern_player #(
        .MAX_LEN(16), .BOX_SIZE(4), .ON_TICKS(10), .ON_STEP(2), .MIN_ON(6), .OFF_TICKS(5)
    ) dut (
        .iClock  (clk),
        .iResetn (iResetn),
        .start   (start),
        .level   (level),
`ifdef PATTERN_PAUSE_EN
        .pause   (pause),
`endif
        .seq_data(seq_data),
        .oX      (oX),
        .oY      (oY),
        .oColour (oColour),
        .oPlot   (oPlot),
        .busy    (busy),
        .done    (done)
    );

    pattern_player #(
        .MAX_LEN(4), .BOX_SIZE(4), .ON_TICKS(10), .ON_STEP(2), .MIN_ON(6), .OFF_TICKS(5)
    ) dut2 (
        .iClock  (clk),
        .iResetn (iResetn),
        .start   (start2),
        .level   (level2),
`ifdef PATTERN_PAUSE_EN
        .pause   (1'b0),
`endif
        .seq_data(seq2),
        .oX      (oX2),
        .oY      (oY2),
        .oColour (oColour2),
        .oPlot   (oPlot2),
        .busy    (busy2),
        .done    (done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, k);
        end
    endtask

    function automatic int on_time(input int l);
        int t;
        t = 10 - (l - 1) * 2;
        return (t < 6) ? 6 : t;
    endfunction

    task automatic push_box(input int b, input logic [2:0] c);
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                exp_q.push_back({8'(bx[b] + col), 7'(by[b] + row), c});
            end
        end
    endtask

    // One clock cycle: sample at the falling edge, score pixels, check busy/done.
    task automatic step();
        logic [17:0] e;
        @(negedge clk);
        k++;
        if (oPlot) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pixel", {14'd0, oX, oY, oColour}, {14'd0, e});
            end else begin
                check("extra_plot", {31'd0, oPlot}, 32'd0);
            end
        end
        check("busy", {31'd0, busy}, {31'd0, (k >= 1 && k <= exp_done_k)});
        check("done", {31'd0, done}, {31'd0, (k == exp_done_k)});
        if (oPlot2) p2++;
        if (done2 && done2_k == 0) done2_k = k;
    endtask

    task automatic play(input int lvl, input logic [31:0] seq, input int rep_a,
                        input int rep_b, input int extra, input int abort_k);
        int l;
        int b;
        l = (lvl == 0) ? 1 : ((lvl > 16) ? 16 : lvl);
        for (int e = 0; e < l; e++) begin
            b = int'(seq[2*e +: 2]);
            push_box(b, 3'(bc[b]));
            push_box(b, 3'd7);
        end
        exp_done_k = l * (5 + on_time(l) + 32) + 1 + extra;
        level    = 4'(lvl);
        seq_data = seq;
        start    = 1'b1;
        k        = 0;
        while (k < exp_done_k + 1 && (abort_k == 0 || k < abort_k)) begin
            step();
            start = (k == rep_a || k == rep_b);
`ifdef PATTERN_PAUSE_EN
            pause = (p_lo > 0 && k >= p_lo && k <= p_hi);
`endif
        end
        start = 1'b0;
`ifdef PATTERN_PAUSE_EN
        pause = 1'b0;
`endif
        if (abort_k > 0) begin
            #2 iResetn = 1'b0;
            #1;
            check("rst_plot", {31'd0, oPlot}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            exp_q.delete();
            exp_done_k = 0;
            step();
            step();
            iResetn = 1'b1;
            repeat (20) step();
        end else begin
            check("drained", exp_q.size(), 32'd0);
        end
    endtask

    initial begin
        iResetn  = 1'b0;
        start    = 1'b0;
        level    = 4'd0;
        seq_data = 32'd0;
        start2   = 1'b0;
        level2   = 4'd0;
        seq2     = 8'd0;
`ifdef PATTERN_PAUSE_EN
        pause    = 1'b0;
`endif
        step();
        step();
        check("reset_x", {24'd0, oX}, 32'd0);
        check("reset_y", {25'd0, oY}, 32'd0);
        check("reset_colour", {29'd0, oColour}, 32'd0);
        check("reset_plot", {31'd0, oPlot}, 32'd0);
        iResetn = 1'b1;
        step();
        step();

        // Single element, box2 blue: done on cycle 48.
        play(1, 32'h0000_0002, 0, 0, 0, 0);
        // Boxes 0,3,3 with start re-pulsed in HOLD and on the DONE cycle.
        play(3, 32'h0000_003C, 25, 130, 0, 0);
        // Accepted on the cycle right after busy falls.
        play(2, 32'h0000_0005, 0, 0, 0, 0);
        // Level 0 plays one element; level 15 hits the hold floor.
        play(0, 32'h0000_0003, 0, 0, 0, 0);
        play(15, $urandom(), 0, 0, 0, 0);

        // Clamp above MAX_LEN on the MAX_LEN=4 instance: 4 elements, done on 173.
        exp_done_k = 0;
        k          = 0;
        level2     = 4'd9;
        seq2       = 8'($urandom_range(0, 255));
        start2     = 1'b1;
        step();
        start2 = 1'b0;
        repeat (185) step();
        check("clamp_plots", p2, 32'd128);
        check("clamp_done", done2_k, 32'd173);

        // Reset during the 5th visible pixel of DRAW, then a clean replay.
        play(1, 32'h0000_0000, 0, 0, 0, 11);
        play(2, 32'($urandom_range(0, 15)), 0, 0, 0, 0);

`ifdef PATTERN_PAUSE_EN
        // Seven paused cycles mid-DRAW extend done by exactly seven.
        p_lo = 12;
        p_hi = 18;
        play(1, 32'h0000_0002, 0, 0, 7, 0);
        p_lo = 0;
        p_hi = 0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Plays a stored memory-game sequence on the VGA adapter as lit boxes in a 2x2 grid.
- Parametrised successor of the fixed two-box pattern display.
  - Sequence length up to MAX_LEN, driven by `level`.
  - Per-element box index taken from a packed sequence word.
  - Per-box colour.
  - Level-dependent on-time speed-up.
- Sits between the game controller (start/done handshake) and the VGA adapter (oX/oY/oColour/oPlot).

Parameters:
- MAX_LEN, 16, maximum sequence length; also the level clamp.
- BOX_SIZE, 24, box edge in pixels; the scan covers BOX_SIZE*BOX_SIZE pixels.
- ON_TICKS, 50000000, box-visible hold cycles at level 1.
- ON_STEP, 2500000, hold reduction per level above 1.
- MIN_ON, 10000000, floor on hold cycles.
- OFF_TICKS, 25000000, blank gap before each element.

Ports:
- iClock  in  1  system clock (50 MHz).
- iResetn  in  1  asynchronous active-low reset.
- start  in  1  request playback; accepted only in IDLE.
- level  in  4  sequence length to play.
- seq_data  in  2*MAX_LEN  packed box indices; element i is at bits [2i+1:2i].
- oX  out  8  pixel x.
- oY  out  7  pixel y.
- oColour  out  3  pixel colour.
- oPlot  out  1  pixel write strobe.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset:
  - iResetn low asynchronously forces IDLE.
  - All counters go to 0.
  - oX=0, oY=0, oColour=0, oPlot=0, busy=0, done=0.
  - Reset mid-playback aborts immediately; no erase of a partly drawn box.
- Level clamp:
  - Effective length L = 1 if level==0.
  - L = MAX_LEN if level>MAX_LEN.
  - Otherwise L = level.
- Start accept:
  - On the edge where state==IDLE and start==1: latch L and seq_data, set element index idx=0, enter GAP.
  - start is ignored in every other state.
- Hold time: on_t = max(MIN_ON, ON_TICKS - (L-1)*ON_STEP), computed once at accept.
- States and transitions:
  - IDLE -> GAP on accept.
  - GAP: OFF_TICKS cycles, then -> DRAW.
  - DRAW: scan box seq[idx] in its colour for BOX_SIZE^2 cycles, then -> HOLD.
  - HOLD: on_t cycles, then -> ERASE.
  - ERASE: rescan the same box in background colour 3'd7, then:
    - if idx==L-1 -> DONE;
    - else idx++ and -> GAP.
  - DONE: done=1 for one cycle, then -> IDLE.
- Pixel scan:
  - Row-major order: (0,0),(1,0)..(B-1,0),(0,1)..(B-1,B-1).
  - oX = box_x+col, oY = box_y+row.
  - oX/oY/oColour/oPlot are registered: oPlot is high for exactly BOX_SIZE^2 consecutive cycles, starting one cycle after DRAW/ERASE entry.
  - Outside scan windows: oPlot=0 and oX/oY/oColour hold their last values.
- Grid positions (x,y):
  - box0 (44,24), box1 (92,24), box2 (44,72), box3 (92,72).
- Box colours: box0 red 3'd4, box1 green 3'd2, box2 blue 3'd1, box3 yellow 3'd6.
- Timing: done is high on cycle L*(OFF_TICKS+on_t+2*BOX_SIZE^2)+1 after the accept edge; busy falls on the following cycle.
- Widths:
  - Timers sized $clog2(max(ON_TICKS,OFF_TICKS)+1).
  - The hold subtraction saturates at MIN_ON; no underflow.
- Repeated indices: the same box in consecutive elements is still erased and separated by GAP.

Optional Feature:
- Macro: PATTERN_PAUSE_EN.
- Defined:
  - Adds input `pause` (1 bit).
  - While pause==1, the GAP/HOLD timers and the scan counter freeze.
  - oPlot is forced 0 during pause; the scan resumes at the same pixel.
  - done timing is extended by exactly the paused cycles.
  - Reset overrides pause.
- Undefined: no pause port; timing exactly as above.

Decomposition:
- Package pattern_pkg holds:
  - the state enum (IDLE, GAP, DRAW, HOLD, ERASE, DONE);
  - the BOX_X/BOX_Y position constants per index;
  - the BOX_COLOUR constants per index;
  - the BG_COLOUR=3'd7 constant.
- Sub-module box_scanner(iClock, iResetn, go, base_x, base_y, colour, oX, oY, oColour, oPlot, last), parametrised by BOX_SIZE. It owns the row/col counters and the registered pixel outputs. pattern_player owns the FSM, timers, idx and the clamp.

Test Plan (BOX_SIZE=4, ON_TICKS=10, ON_STEP=2, MIN_ON=6, OFF_TICKS=5, MAX_LEN=16):
1. level=1, seq[0]=2, pulse start -> 16 plots at x 44..47, y 72..75, colour 1, then 16 plots in colour 7; done high on cycle 48 after accept.
2. level=3, seq=0,3,3 -> on_t=6; boxes 0,3,3 each drawn then erased; done on cycle 3*43+1=130; busy high from cycle 1 to 130.
3. level=0 -> plays one element; level=15 gives on_t=max(6,10-28)=6 (floor); level>MAX_LEN with MAX_LEN=4 -> exactly 4 elements.
4. start re-pulsed during HOLD and on the DONE cycle -> ignored; a new start on the cycle after busy falls is accepted.
5. iResetn low during the 5th pixel of DRAW -> oPlot=0, busy=0, done=0 within the same cycle (async); no further plots until the next start.
6. PATTERN_PAUSE_EN defined: pause high for 7 cycles mid-DRAW -> no plots during pause, no pixel skipped or repeated, done delayed by exactly 7 cycles.
